// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph codes, segment-pattern type and the 180-degree flip remap
// used by the seven-segment display blocks.
package seg7_pkg;

   localparam int unsigned GLYPH_W = 5;
   localparam int unsigned SEG_W   = 7;

   localparam logic [GLYPH_W-1:0] GLYPH_P     = 5'd16;
   localparam logic [GLYPH_W-1:0] GLYPH_Y     = 5'd17;
   localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 5'd18;
   localparam logic [GLYPH_W-1:0] GLYPH_MINUS = 5'd19;

   // Segment pattern {a,b,c,d,e,f,g}, a is the MSB
   typedef logic [SEG_W-1:0] seg_pattern_t;

   // Upside-down rendering: a<->d, b<->e, c<->f, g stays
   function automatic seg_pattern_t seg_flip(input seg_pattern_t s);
      return {s[3], s[2], s[1], s[6], s[5], s[4], s[0]};
   endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// seg7_glyph_decoder: combinational glyph-code to abcdefg segment decoder with
// optional upside-down rendering.
// Ports:
//   i_glyph  - 5-bit glyph code (0-9, A b C d E F, P, Y, blank, minus; 20-31 blank)
//   i_flip   - 1 renders the glyph rotated by 180 degrees
//   o_seg_c  - segment pattern {a,b,c,d,e,f,g}, active-high, combinational
module seg7_glyph_decoder
   import seg7_pkg::*;
(
   input  logic [GLYPH_W-1:0] i_glyph,
   input  logic               i_flip,
   output seg_pattern_t       o_seg_c
);

   seg_pattern_t w_raw;

   // Glyph lookup; every unlisted code renders blank
   always_comb begin
      w_raw = 7'b0000000;
      case (i_glyph)
         5'd0:        w_raw = 7'b1111110;
         5'd1:        w_raw = 7'b0110000;
         5'd2:        w_raw = 7'b1101101;
         5'd3:        w_raw = 7'b1111001;
         5'd4:        w_raw = 7'b0110011;
         5'd5:        w_raw = 7'b1011011;
         5'd6:        w_raw = 7'b1011111;
         5'd7:        w_raw = 7'b1110000;
         5'd8:        w_raw = 7'b1111111;
         5'd9:        w_raw = 7'b1111011;
         5'd10:       w_raw = 7'b1110111;
         5'd11:       w_raw = 7'b0011111;
         5'd12:       w_raw = 7'b1001110;
         5'd13:       w_raw = 7'b0111101;
         5'd14:       w_raw = 7'b1001111;
         5'd15:       w_raw = 7'b1000111;
         GLYPH_P:     w_raw = 7'b1100111;
         GLYPH_Y:     w_raw = 7'b0111011;
         GLYPH_MINUS: w_raw = 7'b0000001;
         default:     w_raw = 7'b0000000;
      endcase
   end

   assign o_seg_c = i_flip ? seg_flip(w_raw) : w_raw;

endmodule

// File: rtl/seg7_scroll_display.sv
// seg7_scroll_display: multiplexed N-digit seven-segment driver with a writable
// glyph message buffer, debounced scroll / flip buttons and 180-degree flip.
// Optional macro SEG7_AUTO_SCROLL_EN adds AUTO_PERIOD and auto_mode (timed scroll).
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   BTN[1:0]     - raw buttons: [0] scroll by one, [1] toggle flip
//   wr_en/wr_addr/wr_glyph - message buffer write port (out-of-range address ignored)
//   auto_mode    - (SEG7_AUTO_SCROLL_EN only) enables timed scrolling
//   seg          - registered segments {a..g}, inverted when ACTIVE_LOW
//   digit_en     - registered one-hot digit select, bit 0 leftmost, inverted when ACTIVE_LOW
//   offset, flip - current scroll position and flip state
module seg7_scroll_display
   import seg7_pkg::*;
#(
   parameter int unsigned N_DIGITS        = 4,
   parameter int unsigned MSG_LEN         = 8,
   parameter int unsigned SCAN_DIV        = 1024,
   parameter int unsigned DEBOUNCE_CYCLES = 65536,
   parameter bit          ACTIVE_LOW      = 1'b0,
`ifdef SEG7_AUTO_SCROLL_EN
   parameter int unsigned AUTO_PERIOD     = 2**24,
`endif
   localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          BTN,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [GLYPH_W-1:0]  wr_glyph,
`ifdef SEG7_AUTO_SCROLL_EN
   input  logic                auto_mode,
`endif
   output logic [SEG_W-1:0]    seg,
   output logic [N_DIGITS-1:0] digit_en,
   output logic [AW-1:0]       offset,
   output logic                flip
);

   localparam int unsigned IW  = AW + 1;
   localparam int unsigned DW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned SW  = $clog2(SCAN_DIV);
   localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [GLYPH_W-1:0]  r_buf [MSG_LEN];
   logic [AW-1:0]       r_offset;
   logic                r_flip;
   logic [SW-1:0]       r_scan;
   logic [DW-1:0]       r_digit;
   seg_pattern_t        r_seg;
   logic [N_DIGITS-1:0] r_digit_en;

   logic [1:0]          w_press;
   logic                w_scroll;
   logic [IW-1:0]       w_sum;
   logic [AW-1:0]       w_rd_idx;
   seg_pattern_t        w_seg;
   logic [N_DIGITS-1:0] w_digit_en;

   // Per-button synchroniser, debounce and rising-edge press detector
   for (genvar b = 0; b < 2; b++) begin : g_btn
      logic           r_s1;
      logic           r_s2;
      logic           r_db;
      logic           r_db_d;
      logic [DBW-1:0] r_cnt;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_s1   <= BTN[b];
            r_s2   <= r_s1;
            r_db_d <= r_db;
            // Count only while the synced level disagrees; any bounce back restarts
            if (r_s2 == r_db) begin
               r_cnt <= '0;
            end else if (r_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
               r_db  <= r_s2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + DBW'(1);
            end
         end
      end

      assign w_press[b] = r_db & ~r_db_d;
   end

`ifdef SEG7_AUTO_SCROLL_EN
   localparam int unsigned PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

   logic [PW-1:0] r_auto_cnt;
   logic          w_auto_tick;

   assign w_auto_tick = auto_mode && (r_auto_cnt == PW'(AUTO_PERIOD - 1));

   // Auto-scroll period counter; a manual scroll restarts the period
   always_ff @(posedge clk) begin
      if (reset || !auto_mode || w_press[0] || w_auto_tick) begin
         r_auto_cnt <= '0;
      end else begin
         r_auto_cnt <= r_auto_cnt + PW'(1);
      end
   end

   // OR-merge so a coincident press and tick advance once
   assign w_scroll = w_press[0] | w_auto_tick;
`else
   assign w_scroll = w_press[0];
`endif

   // Scroll position and flip state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_offset <= '0;
         r_flip   <= 1'b0;
      end else begin
         if (w_scroll) begin
            r_offset <= (r_offset == AW'(MSG_LEN - 1)) ? '0 : r_offset + AW'(1);
         end
         if (w_press[1]) begin
            r_flip <= ~r_flip;
         end
      end
   end

   // Message buffer write port
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(MSG_LEN); i++) begin
            r_buf[i] <= GLYPH_BLANK;
         end
      end else if (wr_en && (IW'(wr_addr) < IW'(MSG_LEN))) begin
         r_buf[wr_addr] <= wr_glyph;
      end
   end

   // Scan divider and active digit index
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan  <= '0;
         r_digit <= '0;
      end else if (r_scan == SW'(SCAN_DIV - 1)) begin
         r_scan  <= '0;
         r_digit <= (r_digit == DW'(N_DIGITS - 1)) ? '0 : r_digit + DW'(1);
      end else begin
         r_scan <= r_scan + SW'(1);
      end
   end

   // Buffer index (offset + digit) mod MSG_LEN; both terms are below MSG_LEN
   always_comb begin
      w_sum    = IW'(r_offset) + IW'(r_digit);
      w_rd_idx = AW'(w_sum);
      if (w_sum >= IW'(MSG_LEN)) begin
         w_rd_idx = AW'(w_sum - IW'(MSG_LEN));
      end
   end

   seg7_glyph_decoder u_decoder (
      .i_glyph (r_buf[w_rd_idx]),
      .i_flip  (r_flip),
      .o_seg_c (w_seg)
   );

   assign w_digit_en = N_DIGITS'(1) << r_digit;

   // Output register: one cycle behind the scan/buffer/flip state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_seg      <= '0;
         r_digit_en <= '0;
      end else begin
         r_seg      <= w_seg;
         r_digit_en <= w_digit_en;
      end
   end

   assign seg      = ACTIVE_LOW ? ~r_seg      : r_seg;
   assign digit_en = ACTIVE_LOW ? ~r_digit_en : r_digit_en;
   assign offset   = r_offset;
   assign flip     = r_flip;

endmodule

// File: tb/tb_seg7_scroll_display.sv
// tb_seg7_scroll_display: self-checking bench for seg7_scroll_display.
// Expected values come from a behavioural model (cycle count since reset,
// message array, offset and flip) and from a table of glyph patterns.
module tb_seg7_scroll_display;

   localparam int unsigned N    = 4;
   localparam int unsigned MSG  = 8;
   localparam int unsigned SCAN = 4;
   localparam int unsigned DB   = 16;
   localparam int unsigned AP   = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] btn;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [4:0] wr_glyph;
   logic [6:0] seg;
   logic [3:0] digit_en;
   logic [2:0] offset;
   logic       flip;
`ifdef SEG7_AUTO_SCROLL_EN
   logic       auto_mode;
`endif

   seg7_scroll_display #(
      .N_DIGITS        (N),
      .MSG_LEN         (MSG),
      .SCAN_DIV        (SCAN),
      .DEBOUNCE_CYCLES (DB),
`ifdef SEG7_AUTO_SCROLL_EN
      .AUTO_PERIOD     (AP),
`endif
      .ACTIVE_LOW      (1'b0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .BTN      (btn),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_glyph (wr_glyph),
`ifdef SEG7_AUTO_SCROLL_EN
      .auto_mode(auto_mode),
`endif
      .seg      (seg),
      .digit_en (digit_en),
      .offset   (offset),
      .flip     (flip)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] glyph;
      logic [6:0] seg;
   } vec_t;

   vec_t       vecs [24];
   logic [4:0] m_buf [MSG];
   int         m_off;
   bit         m_flip;
   int         m_k;
   bit         check_en;
   int         n_chk;
   int         n_err;
   int         lat;

   // Glyph pattern from the table; codes 20-31 render blank
   function automatic logic [6:0] pat(input logic [4:0] g);
      return (g < 5'd20) ? vecs[g].seg : 7'b0000000;
   endfunction

   // Rotating a seven-segment digit by 180 degrees swaps a/d, b/e, c/f
   function automatic logic [6:0] rot180(input logic [6:0] s);
      logic [6:0] r;
      r = s;
      for (int j = 0; j < 3; j++) begin
         r[6-j] = s[3-j];
         r[3-j] = s[6-j];
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: predict the registered outputs from the pre-edge model state
   task automatic tick();
      int         d;
      logic [3:0] ed;
      logic [6:0] es;
      d  = (m_k / SCAN) % N;
      ed = 4'(1 << d);
      es = pat(m_buf[(m_off + d) % MSG]);
      if (m_flip) es = rot180(es);
      if (wr_en) m_buf[wr_addr] = wr_glyph;
      @(posedge clk);
      #1;
      m_k++;
      if (check_en) begin
         chk("digit_en", 32'(digit_en), 32'(ed));
         chk("seg", 32'(seg), 32'(es));
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      chk("rst_seg", 32'(seg), 32'd0);
      chk("rst_digit_en", 32'(digit_en), 32'd0);
      chk("rst_offset", 32'(offset), 32'd0);
      chk("rst_flip", 32'(flip), 32'd0);
      reset  = 1'b0;
      m_k    = 0;
      m_off  = 0;
      m_flip = 1'b0;
      for (int i = 0; i < MSG; i++) m_buf[i] = 5'd18;
   endtask

   task automatic write(input int a, input int g);
      wr_en    = 1'b1;
      wr_addr  = 3'(a);
      wr_glyph = 5'(g);
      tick();
      wr_en    = 1'b0;
   endtask

   // Advance until digit d is being driven (bounded)
   task automatic wait_digit(input int d);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 2 * N * SCAN && !found; i++) begin
         if (digit_en == 4'(1 << d)) found = 1'b1;
         else tick();
      end
      if (!found) begin
         n_chk++;
         n_err++;
         $display("FAIL wait_digit%0d: digit_en=%b never reached expected %b", d, digit_en, 4'(1 << d));
      end
   endtask

   // Clean press and release of button b; checks latency and resulting state
   task automatic press(input int b);
      check_en = 1'b0;
      lat      = -1;
      btn[b]   = 1'b1;
      for (int i = 1; i <= DB + 12; i++) begin
         tick();
         if (lat < 0 && ((b == 0) ? (offset != 3'(m_off)) : (flip != m_flip))) lat = i;
      end
      btn[b] = 1'b0;
      repeat (DB + 8) tick();
      if (b == 0) begin
         m_off = (m_off + 1) % MSG;
         chk("press_offset", 32'(offset), 32'(m_off));
      end else begin
         m_flip = !m_flip;
         chk("press_flip", 32'(flip), 32'(m_flip));
      end
      n_chk++;
      if (lat < DB || lat > DB + 6) begin
         n_err++;
         $display("FAIL press_latency btn%0d: got %0d cycles expected %0d..%0d", b, lat, DB, DB + 6);
      end
      check_en = 1'b1;
   endtask

   initial begin
      logic [6:0] t1_seg [4];
      int         t_prev;
      int         t_now;

      vecs[0]  = '{5'd0,  7'b1111110};  vecs[1]  = '{5'd1,  7'b0110000};
      vecs[2]  = '{5'd2,  7'b1101101};  vecs[3]  = '{5'd3,  7'b1111001};
      vecs[4]  = '{5'd4,  7'b0110011};  vecs[5]  = '{5'd5,  7'b1011011};
      vecs[6]  = '{5'd6,  7'b1011111};  vecs[7]  = '{5'd7,  7'b1110000};
      vecs[8]  = '{5'd8,  7'b1111111};  vecs[9]  = '{5'd9,  7'b1111011};
      vecs[10] = '{5'd10, 7'b1110111};  vecs[11] = '{5'd11, 7'b0011111};
      vecs[12] = '{5'd12, 7'b1001110};  vecs[13] = '{5'd13, 7'b0111101};
      vecs[14] = '{5'd14, 7'b1001111};  vecs[15] = '{5'd15, 7'b1000111};
      vecs[16] = '{5'd16, 7'b1100111};  vecs[17] = '{5'd17, 7'b0111011};
      vecs[18] = '{5'd18, 7'b0000000};  vecs[19] = '{5'd19, 7'b0000001};
      vecs[20] = '{5'd20, 7'b0000000};  vecs[21] = '{5'd25, 7'b0000000};
      vecs[22] = '{5'd31, 7'b0000000};  vecs[23] = '{5'd18, 7'b0000000};
      t1_seg[0] = 7'b1100111; t1_seg[1] = 7'b0111011;
      t1_seg[2] = 7'b1111110; t1_seg[3] = 7'b0110000;

      n_chk = 0; n_err = 0; check_en = 1'b1;
      btn = 2'b00; wr_en = 1'b0; wr_addr = '0; wr_glyph = '0;
`ifdef SEG7_AUTO_SCROLL_EN
      auto_mode = 1'b0;
`endif
      #1;
      do_reset(3);

      // First cycles after reset: digit 0 selected, blank buffer
      tick();
      chk("first_digit_en", 32'(digit_en), 32'd1);
      chk("first_seg", 32'(seg), 32'd0);

      // Message P Y 0 1 and digit rotation
      write(0, 16); write(1, 17); write(2, 0); write(3, 1);
      repeat (2 * N * SCAN) tick();
      for (int d = 0; d < N; d++) begin
         wait_digit(d);
         chk($sformatf("scan_seg_d%0d", d), 32'(seg), 32'(t1_seg[d]));
      end

      // Glyph table, upright
      for (int i = 0; i < 24; i++) begin
         write(0, int'(vecs[i].glyph));
         tick();
         wait_digit(0);
         chk($sformatf("tbl_g%0d", vecs[i].glyph), 32'(seg), 32'(vecs[i].seg));
      end
      write(0, 16);
      tick();

      // Flip on: P and Y rendered upside-down
      press(1);
      chk("flip_on", 32'(flip), 32'd1);
      wait_digit(0);
      chk("flip_P", 32'(seg), 32'(7'b0111101));
      wait_digit(1);
      chk("flip_Y", 32'(seg), 32'(7'b1010111));
      for (int i = 0; i < 24; i++) begin
         write(2, int'(vecs[i].glyph));
         tick();
         wait_digit(2);
         chk($sformatf("tblf_g%0d", vecs[i].glyph), 32'(seg), 32'(rot180(vecs[i].seg)));
      end
      press(1);

      // Random writes checked every cycle against the model
      for (int i = 0; i < 300; i++) begin
         wr_en    = 1'($urandom_range(0, 1));
         wr_addr  = 3'($urandom_range(0, MSG - 1));
         wr_glyph = 5'($urandom_range(0, 31));
         tick();
      end
      wr_en = 1'b0;
      for (int a = 0; a < MSG; a++) write(a, a + 2);

      // Scroll through all positions and wrap
      for (int p = 0; p < MSG; p++) begin
         press(0);
         wait_digit(0);
         chk($sformatf("scroll_d0_off%0d", m_off), 32'(seg), 32'(pat(m_buf[m_off])));
      end
      chk("scroll_wrapped", 32'(offset), 32'd0);

      // Short glitch: no event
      btn[0] = 1'b1;
      repeat (5) tick();
      btn[0] = 1'b0;
      repeat (DB + 8) tick();
      chk("glitch_offset", 32'(offset), 32'(m_off));

      // Bouncing input then a stable hold: exactly one scroll
      check_en = 1'b0;
      for (int t = 0; t < 10; t++) begin
         btn[0] = ~btn[0];
         repeat (DB / 2) tick();
      end
      btn[0] = 1'b1;
      repeat (DB + 12) tick();
      btn[0] = 1'b0;
      repeat (DB + 8) tick();
      m_off = (m_off + 1) % MSG;
      chk("bounce_offset", 32'(offset), 32'(m_off));
      check_en = 1'b1;

      // Reset mid-scan and mid-debounce with offset 3 and flip on
      press(0); press(0); press(1);
      chk("pre_rst_offset", 32'(offset), 32'd3);
      chk("pre_rst_flip", 32'(flip), 32'd1);
      repeat (2) tick();
      btn[0] = 1'b1;
      repeat (DB / 2) tick();
      btn[0] = 1'b0;
      do_reset(1);
      tick();
      chk("post_rst_digit_en", 32'(digit_en), 32'd1);
      repeat (DB + 8) tick();
      chk("post_rst_offset", 32'(offset), 32'd0);
      chk("post_rst_flip", 32'(flip), 32'd0);

`ifdef SEG7_AUTO_SCROLL_EN
      // Timed scroll every AP cycles
      check_en  = 1'b0;
      auto_mode = 1'b1;
      t_prev    = 0;
      for (int n = 0; n < 3; n++) begin
         t_now = -1;
         for (int i = 1; i <= AP + 4 && t_now < 0; i++) begin
            tick();
            if (offset != 3'(m_off)) t_now = i;
         end
         m_off = (m_off + 1) % MSG;
         chk($sformatf("auto_period%0d", n), 32'(t_now), 32'(AP));
         t_prev = t_now;
      end
      auto_mode = 1'b0;
      tick();
      chk("auto_offset", 32'(offset), 32'(m_off));
      check_en = 1'b1;
      repeat (N * SCAN) tick();
`else
      t_prev = 0;
      t_now  = 0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/seg7_scroll_display.md
# seg7_scroll_display

Multiplexed N-digit seven-segment display driver with a writable glyph message buffer, button-controlled scrolling and 180° flip. Button inputs are synchronised and debounced. The digits are time-multiplexed one at a time. Each glyph is decoded to abcdefg segments, and the flip option renders the glyph upside-down. The block sits between the board buttons/GPIO and the segment and digit-select pins, replacing per-exercise combinational letter logic.

## Interface
- `N_DIGITS`, 4: number of physical digits, 1..8.
- `MSG_LEN`, 8: message buffer depth in glyphs, ≥ `N_DIGITS`, ≤ 32.
- `SCAN_DIV`, 1024: clock cycles each digit stays enabled, ≥ 2.
- `DEBOUNCE_CYCLES`, 65536: cycles a synchronised button must be stable before it is accepted.
- `ACTIVE_LOW`, 0: 1 inverts `seg` and `digit_en` at the outputs.
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `BTN` input 2: raw buttons. `BTN[0]` scrolls by one position. `BTN[1]` toggles flip.
- `wr_en` input 1: message write strobe.
- `wr_addr` input $clog2(MSG_LEN): buffer index.
- `wr_glyph` input 5: glyph code.
- `seg` output 7: segments {a,b,c,d,e,f,g}, with a as the MSB.
- `digit_en` output N_DIGITS: one-hot digit select. Bit 0 is the leftmost digit.
- `offset` output $clog2(MSG_LEN): current scroll position.
- `flip` output 1: current flip state.

## Operation
- **Glyph codes:**
  - 0–9 are decimal digits.
  - 10–15 are A,b,C,d,E,F.
  - 16 is P, 17 is Y, 18 is blank, 19 is minus.
  - 20–31 are blank.
  - Segment patterns (abcdefg): 0=1111110, P=1100111, Y=0111011, minus=0000001, blank=0000000.
- **Flip:** remaps the decoded segments a↔d, b↔e, c↔f, with g unchanged. For example, P 1100111 → 0111101 and Y 0111011 → 1010111.
- **Digit mapping:** digit i displays `buffer[(offset + i) mod MSG_LEN]`.
- **Button path:**
  - Two-flop synchroniser per button.
  - A per-button debounce counter restarts whenever the synchronised level differs from the debounced level.
  - The debounced level updates when the counter reaches `DEBOUNCE_CYCLES`-1.
  - A 0→1 transition of the debounced level produces a one-cycle press event.
- **Scroll:** a press on `BTN[0]` increments `offset`, wrapping from `MSG_LEN`-1 to 0.
- **Flip toggle:** a press on `BTN[1]` toggles `flip`.
- **Scan state:**
  - Scan counter runs 0..`SCAN_DIV`-1.
  - On wrap, the digit index advances from `N_DIGITS`-1 to 0.
  - `N_DIGITS`=1 keeps the digit index at 0 permanently.
- **Writes:**
  - `wr_en` writes `wr_glyph` into the buffer in the same cycle.
  - Writes are accepted every cycle; there is no backpressure.
  - An out-of-range `wr_addr` (≥ `MSG_LEN`) is ignored.
- **Simultaneous events:** a write, a scroll event and a flip event in the same cycle all take effect. Display reads use the post-update state from the following cycle.

## Timing
- **Reset values:** `seg`=0, `digit_en`=0, `offset`=0, `flip`=0, buffer all blank (18), scan counter 0, digit index 0, debounced levels 0. Polarities above are before `ACTIVE_LOW` inversion.
- **Output register:** `seg` and `digit_en` are registered. They reflect the digit index, buffer, `offset` and `flip` of the previous cycle, giving 1-cycle latency.
- **First outputs after reset:**
  - The first cycle after `reset` deasserts drives `digit_en`=0001 with digit 0's glyph.
  - The enable moves to the next digit one cycle after each scan-counter wrap.
- **`digit_en` encoding:** always exactly one-hot out of reset, never zero and never multi-hot.
- **Button latency:** a clean press is seen as an event 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles after the raw edge. `offset` and `flip` update on the cycle after the event.
- **Reset mid-operation:** `reset` mid-scan or mid-debounce returns every state element to its reset value on the next edge. A partial debounce never produces an event.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` produces no event.

## Configuration
- **`SEG7_AUTO_SCROLL_EN` defined:**
  - Adds parameter `AUTO_PERIOD` (default 2**24) and input `auto_mode` (1 bit).
  - While `auto_mode`=1, `offset` increments every `AUTO_PERIOD` cycles.
  - The period counter restarts on every `BTN[0]` press event and whenever `auto_mode` is 0.
  - A manual press and an auto tick in the same cycle increment `offset` once only.
- **`SEG7_AUTO_SCROLL_EN` undefined:** neither `AUTO_PERIOD`, `auto_mode` nor the counter exist, and `offset` changes only on `BTN[0]` presses.

## Structure
- **Shared package `seg7_pkg`:**
  - Glyph code constants: `GLYPH_P`=16, `GLYPH_Y`=17, `GLYPH_BLANK`=18, `GLYPH_MINUS`=19.
  - 7-bit segment-pattern typedef.
  - Flip-mapping function.
- **Sub-module `seg7_glyph_decoder`:** combinational 5-bit glyph plus flip in, 7-bit segments out. It is reused by later blocks.
- **Debounce:** implemented as a generate loop over the 2 buttons inside the top level.

## Test plan
- **Reset:** apply reset, then write buffer[0..3] = {16,17,0,1} with `N_DIGITS`=4, `SCAN_DIV`=4. Expect `digit_en` to cycle 0001→0010→0100→1000 every 4 cycles and `seg` to show 1100111, 0111011, 1111110, 0110000.
- **Flip:** hold `BTN[1]` for `DEBOUNCE_CYCLES`+4 cycles. Expect `flip`=1, digit 0 `seg`=0111101 and digit 1 `seg`=1010111.
- **Scroll wrap:** issue 8 clean `BTN[0]` presses with `MSG_LEN`=8. Expect `offset` 1..7 then 0, and digit 0 to show buffer[offset] each time.
- **Bounce:** toggle `BTN[0]` every `DEBOUNCE_CYCLES`/2 cycles 10 times, then hold it high. Expect exactly one `offset` increment.
- **Reset mid-operation:** assert `reset` mid-scan with `offset`=3 and `flip`=1. Expect every output 0, buffer blank and `digit_en`=0001 on the first cycle after release.
- **Auto scroll (`SEG7_AUTO_SCROLL_EN`):** set `AUTO_PERIOD`=16 and `auto_mode`=1. Expect `offset` to increment every 16 cycles. A manual press coinciding with a tick yields +1 only.
